flkc_gain_clip: RTL and testbench
=================================

FLKC_GAIN_CLIP -- requirements
Module: flkc_gain_clip

Interface
REQ-001 SHALL have parameter P_K_BIT, default 14: output pixel width per channel.
REQ-002 SHALL have parameter P_CH_NUM, default 2: channels per beat.
REQ-003 SHALL have parameter P_IN_BIT, default 25: signed input sample width per channel (gain-stage output).
REQ-004 SHALL have parameter P_SFT_BIT, default 4: width of cfg_y_gain_sft.
REQ-005 SHALL have parameter P_CNT_BIT, default 16: width of clip_cnt.
REQ-006 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1: synchronous, active-low reset.
REQ-008 SHALL have ports s_valid in 1, s_ready out 1, s_sof in 1, s_eof in 1: upstream handshake and frame flags.
REQ-009 SHALL have port s_data  in  P_CH_NUM*P_IN_BIT: signed two's-complement samples; channel 0 in the LSBs.
REQ-010 SHALL have ports cfg_y_gain_sft in P_SFT_BIT, cfg_thres_bayer in P_K_BIT, cfg_clip_en in 1: right-shift amount, upper clip threshold, threshold enable.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_sof out 1, m_eof out 1, m_data out P_CH_NUM*P_K_BIT: downstream stream.
REQ-012 SHALL have ports clip_cnt out P_CNT_BIT, clip_cnt_vld out 1: clipped-sample count of the last completed frame, plus a 1-cycle strobe.

Function
REQ-013 A beat SHALL transfer when valid and ready are both 1 on a rising edge (s_* and m_* alike).
REQ-014 SHALL be a 2-stage pipeline with advance enable en = !m_valid | m_ready; s_ready SHALL equal en.
REQ-015 Stage 1 SHALL register each channel as an arithmetic right shift of s_data by the frame-latched shift (sign preserved).
REQ-016 Stage 2 SHALL clamp per channel: value < 0 -> 0; else if cfg_clip_en latched and value > thres -> thres; else if value > 2**P_K_BIT-1 -> 2**P_K_BIT-1; else value[P_K_BIT-1:0].
REQ-017 Latency s_data accept -> m_data valid SHALL be 2 cycles with m_ready held 1; throughput 1 beat/cycle.
REQ-018 While m_valid=1 and m_ready=0, m_data/m_sof/m_eof SHALL hold stable, no stage SHALL advance, and no beat SHALL be lost or duplicated.
REQ-019 sof/eof SHALL travel with their data beat through both stages.
REQ-020 cfg_y_gain_sft, cfg_thres_bayer and cfg_clip_en SHALL be latched on the accepted s_sof beat and applied to that beat and all beats up to the next s_sof; before the first sof after reset, the values are sft 0, thres max, clip_en 0.
REQ-021 An internal counter SHALL add the number of channels clamped (low or high) in each output beat at m-side transfer, saturating at 2**P_CNT_BIT-1.
REQ-022 On the transfer of an m_eof beat, clip_cnt SHALL load the count including that beat, clip_cnt_vld SHALL pulse 1 cycle, and the internal counter SHALL clear.
REQ-023 An m_sof beat SHALL restart the internal counter with only its own clips (a partial frame without eof is discarded, no strobe).
REQ-024 A beat carrying both sof and eof SHALL be a complete one-beat frame (restart, then load and strobe).
REQ-025 clip_cnt SHALL hold its value until the next eof transfer.

Reset
REQ-026 With rst_n=0 at a clock edge, all pipeline valids, m_valid, m_sof, m_eof, m_data, clip_cnt, clip_cnt_vld and the internal counter SHALL be 0, and the latched config SHALL take its REQ-020 defaults.
REQ-027 Reset mid-frame SHALL drop in-flight beats, and no strobe SHALL follow; s_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-028 Widths P_K_BIT, P_IN_BIT, P_SFT_BIT and the pixel max constant SHALL come from the shared parameter package, with P_IN_BIT equal to the package's pedestal-restored pixel width.
REQ-029 The per-channel shift and clamp SHALL be one sub-module, flkc_clip_ch, instantiated P_CH_NUM times, with a 1-bit clipped flag output.

Verification
REQ-030 sof beat with sft=0, clip_en=0, inputs {1000, 16383}, m_ready=1 -> m_data {1000, 16383} exactly 2 cycles later, no clips.
REQ-031 Inputs {-5, 20000}, sft=0 -> {0, 16383}; eof on the same beat -> clip_cnt=2 and a 1-cycle clip_cnt_vld.
REQ-032 sft=4, clip_en=1, thres=8000, input 262144 -> 8000; input 64000 -> 4000, unclipped.
REQ-033 Continuous stream with m_ready low for 3 cycles mid-frame -> outputs held stable; the output sequence equals the input sequence with no loss or duplication.
REQ-034 cfg_y_gain_sft changed 2->0 mid-frame -> remaining beats still shifted by 2; the next sof frame uses 0.
REQ-035 rst_n low for 1 cycle with 2 beats in flight -> m_valid=0 and clip_cnt=0 next cycle, and a later frame is processed normally.

Source files
------------

// File: rtl/flkc_gain_clip_pkg.sv
// Shared widths, constants and sideband types for the FLKC gain/clip stage.
package flkc_gain_clip_pkg;

    localparam int FLKC_K_BIT   = 14;
    // Pedestal-restored pixel width coming out of the gain multiplier.
    localparam int FLKC_PIX_BIT = 25;
    localparam int FLKC_SFT_BIT = 4;
    localparam int FLKC_CNT_BIT = 16;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eof;
    } flkc_ctl_t;

    function automatic int flkc_pix_max(input int k_bit);
        return (1 << k_bit) - 1;
    endfunction

endpackage

// File: rtl/flkc_clip_ch.sv
// One channel of the gain/clip pipe: stage 1 arithmetic right shift,
// stage 2 clamp to the output pixel range with a clipped flag.
module flkc_clip_ch
    import flkc_gain_clip_pkg::*;
#(
    parameter int P_IN_BIT  = FLKC_PIX_BIT,
    parameter int P_K_BIT   = FLKC_K_BIT,
    parameter int P_SFT_BIT = FLKC_SFT_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [P_IN_BIT-1:0]  sample_i,
    input  logic [P_SFT_BIT-1:0] sft_i,
    input  logic [P_K_BIT-1:0]   thres_i,
    input  logic                 clip_en_i,
    output logic [P_K_BIT-1:0]   pix_o,
    output logic                 clipped_o
);

    localparam logic signed [P_IN_BIT-1:0] PIX_MAX_EXT = P_IN_BIT'(flkc_pix_max(P_K_BIT));
    localparam logic [P_K_BIT-1:0]         PIX_MAX_K   = P_K_BIT'(flkc_pix_max(P_K_BIT));

    logic signed [P_IN_BIT-1:0] shift_d;
    logic signed [P_IN_BIT-1:0] shift_q;
    logic signed [P_IN_BIT-1:0] thres_ext;
    logic [P_K_BIT-1:0]         pix_d;
    logic [P_K_BIT-1:0]         pix_q;
    logic                       clipped_d;
    logic                       clipped_q;

    assign shift_d   = $signed(sample_i) >>> sft_i;
    assign thres_ext = $signed({{(P_IN_BIT - P_K_BIT){1'b0}}, thres_i});

    // thres_i / clip_en_i belong to the beat now held in stage 1, not the incoming one.
    always_comb begin
        pix_d     = shift_q[P_K_BIT-1:0];
        clipped_d = 1'b0;
        if (shift_q[P_IN_BIT-1]) begin
            pix_d     = '0;
            clipped_d = 1'b1;
        end else if (clip_en_i && (shift_q > thres_ext)) begin
            pix_d     = thres_i;
            clipped_d = 1'b1;
        end else if (shift_q > PIX_MAX_EXT) begin
            pix_d     = PIX_MAX_K;
            clipped_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= '0;
            pix_q     <= '0;
            clipped_q <= 1'b0;
        end else if (en_i) begin
            shift_q   <= shift_d;
            pix_q     <= pix_d;
            clipped_q <= clipped_d;
        end
    end

    assign pix_o     = pix_q;
    assign clipped_o = clipped_q;

endmodule

// File: rtl/flkc_gain_clip.sv
// Two-stage shift/clamp pipe for P_CH_NUM channels with per-frame config
// latching and a per-frame clipped-sample counter.
module flkc_gain_clip
    import flkc_gain_clip_pkg::*;
#(
    parameter int P_K_BIT   = FLKC_K_BIT,
    parameter int P_CH_NUM  = 2,
    parameter int P_IN_BIT  = FLKC_PIX_BIT,
    parameter int P_SFT_BIT = FLKC_SFT_BIT,
    parameter int P_CNT_BIT = FLKC_CNT_BIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_sof,
    input  logic                         s_eof,
    input  logic [P_CH_NUM*P_IN_BIT-1:0] s_data,
    input  logic [P_SFT_BIT-1:0]         cfg_y_gain_sft,
    input  logic [P_K_BIT-1:0]           cfg_thres_bayer,
    input  logic                         cfg_clip_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_sof,
    output logic                         m_eof,
    output logic [P_CH_NUM*P_K_BIT-1:0]  m_data,
    output logic [P_CNT_BIT-1:0]         clip_cnt,
    output logic                         clip_cnt_vld
);

    localparam int                   ADD_BIT = $clog2(P_CH_NUM + 1);
    localparam logic [P_CNT_BIT-1:0] CNT_MAX = '1;

    logic                 en;
    logic                 s_fire;
    logic                 m_fire;
    logic                 s_sof_beat;

    logic [P_SFT_BIT-1:0] sft_q;
    logic [P_SFT_BIT-1:0] sft_eff;
    logic [P_K_BIT-1:0]   thres_q;
    logic [P_K_BIT-1:0]   thres_eff;
    logic [P_K_BIT-1:0]   thres1_q;
    logic                 clip_en_q;
    logic                 clip_en_eff;
    logic                 clip_en1_q;

    flkc_ctl_t            ctl1_d;
    flkc_ctl_t            ctl1_q;
    flkc_ctl_t            ctl2_q;

    logic [P_CH_NUM-1:0]  clipped;
    logic [ADD_BIT-1:0]   clip_add;
    logic [P_CNT_BIT-1:0] cnt_base;
    logic [P_CNT_BIT:0]   cnt_sum;
    logic [P_CNT_BIT-1:0] cnt_next;
    logic [P_CNT_BIT-1:0] cnt_q;
    logic [P_CNT_BIT-1:0] clip_cnt_q;
    logic                 clip_cnt_vld_q;

    assign en         = !ctl2_q.vld || m_ready;
    assign s_ready    = en;
    assign s_fire     = s_valid && en;
    assign m_fire     = ctl2_q.vld && m_ready;
    assign s_sof_beat = s_valid && s_sof;

    // A sof beat is processed with the config on the pins; the rest of its frame uses the latched copy.
    assign sft_eff     = s_sof_beat ? cfg_y_gain_sft  : sft_q;
    assign thres_eff   = s_sof_beat ? cfg_thres_bayer : thres_q;
    assign clip_en_eff = s_sof_beat ? cfg_clip_en     : clip_en_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sft_q     <= '0;
            thres_q   <= '1;
            clip_en_q <= 1'b0;
        end else if (s_fire && s_sof) begin
            sft_q     <= cfg_y_gain_sft;
            thres_q   <= cfg_thres_bayer;
            clip_en_q <= cfg_clip_en;
        end
    end

    always_comb begin
        ctl1_d     = '0;
        ctl1_d.vld = s_valid;
        ctl1_d.sof = s_valid && s_sof;
        ctl1_d.eof = s_valid && s_eof;
    end

    // Threshold and enable ride along with the beat so stage 2 clamps with its own frame's config.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl1_q     <= '0;
            ctl2_q     <= '0;
            thres1_q   <= '1;
            clip_en1_q <= 1'b0;
        end else if (en) begin
            ctl1_q     <= ctl1_d;
            ctl2_q     <= ctl1_q;
            thres1_q   <= thres_eff;
            clip_en1_q <= clip_en_eff;
        end
    end

    for (genvar ch = 0; ch < P_CH_NUM; ch++) begin : g_ch
        flkc_clip_ch #(
            .P_IN_BIT  (P_IN_BIT),
            .P_K_BIT   (P_K_BIT),
            .P_SFT_BIT (P_SFT_BIT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en),
            .sample_i  (s_data[ch*P_IN_BIT +: P_IN_BIT]),
            .sft_i     (sft_eff),
            .thres_i   (thres1_q),
            .clip_en_i (clip_en1_q),
            .pix_o     (m_data[ch*P_K_BIT +: P_K_BIT]),
            .clipped_o (clipped[ch])
        );
    end

    // A sof beat starts the count from its own clips, dropping any unterminated frame.
    always_comb begin
        clip_add = '0;
        for (int ch = 0; ch < P_CH_NUM; ch++) begin
            clip_add = clip_add + ADD_BIT'(clipped[ch]);
        end
        cnt_base = ctl2_q.sof ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + (P_CNT_BIT + 1)'(clip_add);
        cnt_next = cnt_sum[P_CNT_BIT] ? CNT_MAX : cnt_sum[P_CNT_BIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            clip_cnt_q     <= '0;
            clip_cnt_vld_q <= 1'b0;
        end else begin
            clip_cnt_vld_q <= 1'b0;
            if (m_fire) begin
                if (ctl2_q.eof) begin
                    clip_cnt_q     <= cnt_next;
                    clip_cnt_vld_q <= 1'b1;
                    cnt_q          <= '0;
                end else begin
                    cnt_q <= cnt_next;
                end
            end
        end
    end

    assign m_valid      = ctl2_q.vld;
    assign m_sof        = ctl2_q.sof;
    assign m_eof        = ctl2_q.eof;
    assign clip_cnt     = clip_cnt_q;
    assign clip_cnt_vld = clip_cnt_vld_q;

endmodule

// File: tb/tb_flkc_gain_clip.sv
// Directed plus randomized bench for flkc_gain_clip against a frame-level reference model.
module tb_flkc_gain_clip;

    localparam int K       = 14;
    localparam int CH      = 2;
    localparam int INB     = 25;
    localparam int SB      = 4;
    localparam int CB      = 16;
    localparam int MAXPIX  = (1 << K) - 1;
    localparam int CNT_MAX = (1 << CB) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic            s_sof;
    logic            s_eof;
    logic [CH*INB-1:0] s_data;
    logic [SB-1:0]   cfg_y_gain_sft;
    logic [K-1:0]    cfg_thres_bayer;
    logic            cfg_clip_en;
    logic            m_valid;
    logic            m_ready;
    logic            m_sof;
    logic            m_eof;
    logic [CH*K-1:0] m_data;
    logic [CB-1:0]   clip_cnt;
    logic            clip_cnt_vld;

    always #5 clk = ~clk;

    flkc_gain_clip #(
        .P_K_BIT   (K),
        .P_CH_NUM  (CH),
        .P_IN_BIT  (INB),
        .P_SFT_BIT (SB),
        .P_CNT_BIT (CB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_sof           (s_sof),
        .s_eof           (s_eof),
        .s_data          (s_data),
        .cfg_y_gain_sft  (cfg_y_gain_sft),
        .cfg_thres_bayer (cfg_thres_bayer),
        .cfg_clip_en     (cfg_clip_en),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_sof           (m_sof),
        .m_eof           (m_eof),
        .m_data          (m_data),
        .clip_cnt        (clip_cnt),
        .clip_cnt_vld    (clip_cnt_vld)
    );

    typedef struct {
        logic [CH*K-1:0] data;
        logic            sof;
        logic            eof;
        int              nclip;
    } beat_t;

    beat_t expq[$];

    int total = 0;
    int bad   = 0;

    logic           rstReq;
    int             cfgSftReq;
    int             cfgThresReq;
    bit             cfgClipEnReq;

    int             mSft    = 0;
    int             mThres  = MAXPIX;
    bit             mClipEn = 0;
    int             mCnt    = 0;
    int             expCnt  = 0;
    bit             expVld  = 0;
    bit             vldNext = 0;
    int             pendCnt = 0;
    bit             stallPrev = 0;
    int             vldCount  = 0;

    logic            lastValid;
    logic [CH*K-1:0] lastData;
    logic            lastSReady;
    logic [CB-1:0]   lastClipCnt;
    logic [CH*K-1:0] lastFireData;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Spec-level clamp of one sample after the frame's right shift.
    function automatic int modelPix(input int sample, input int sft, input int thres,
                                    input bit clipEn, output bit clipped);
        int v;
        v = sample >>> sft;
        clipped = 1'b1;
        if (v < 0) return 0;
        if (clipEn && v > thres) return thres;
        if (v > MAXPIX) return MAXPIX;
        clipped = 1'b0;
        return v;
    endfunction

    function automatic int rndSample();
        case ($urandom_range(0, 3))
            0:       return -int'($urandom_range(1, 5000));
            1:       return int'($urandom_range(0, MAXPIX));
            2:       return int'($urandom_range(0, (1 << 24) - 1));
            default: return int'($urandom_range(0, 70000));
        endcase
    endfunction

    task automatic applyStimulus(input bit v, input bit sof, input bit eof,
                                 input int d0, input int d1, input bit rdy);
        beat_t e;
        bit    c0;
        bit    c1;
        int    p0;
        int    p1;
        int    nv;
        @(negedge clk);
        rst_n           = rstReq;
        s_valid         = v;
        s_sof           = sof;
        s_eof           = eof;
        s_data          = {INB'(d1), INB'(d0)};
        cfg_y_gain_sft  = SB'(cfgSftReq);
        cfg_thres_bayer = K'(cfgThresReq);
        cfg_clip_en     = cfgClipEnReq;
        m_ready         = rdy;
        #1;
        lastValid   = m_valid;
        lastData    = m_data;
        lastSReady  = s_ready;
        lastClipCnt = clip_cnt;
        if (rst_n) begin
            checkOutput("clip_cnt_vld", clip_cnt_vld, expVld);
            checkOutput("clip_cnt", clip_cnt, expCnt);
            if (clip_cnt_vld) vldCount++;
            if (stallPrev) checkOutput("hold_valid", m_valid, 1);
            if (m_valid && !m_ready && expq.size() > 0) begin
                checkOutput("hold_data", m_data, expq[0].data);
                checkOutput("hold_sof", m_sof, expq[0].sof);
                checkOutput("hold_eof", m_eof, expq[0].eof);
            end
            if (m_valid && m_ready) begin
                checkOutput("beat_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    checkOutput("m_data", m_data, e.data);
                    checkOutput("m_sof", m_sof, e.sof);
                    checkOutput("m_eof", m_eof, e.eof);
                    lastFireData = m_data;
                    nv = (e.sof ? 0 : mCnt) + e.nclip;
                    if (nv > CNT_MAX) nv = CNT_MAX;
                    if (e.eof) begin
                        pendCnt = nv;
                        vldNext = 1'b1;
                        mCnt    = 0;
                    end else begin
                        mCnt = nv;
                    end
                end
            end
            stallPrev = m_valid && !m_ready;
            if (v && s_ready) begin
                if (sof) begin
                    mSft    = cfgSftReq;
                    mThres  = cfgThresReq;
                    mClipEn = cfgClipEnReq;
                end
                p0 = modelPix(d0, mSft, mThres, mClipEn, c0);
                p1 = modelPix(d1, mSft, mThres, mClipEn, c1);
                e.data  = {K'(p1), K'(p0)};
                e.sof   = sof;
                e.eof   = eof;
                e.nclip = int'(c0) + int'(c1);
                expq.push_back(e);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            expq.delete();
            mCnt = 0; expCnt = 0; expVld = 0; vldNext = 0; stallPrev = 0;
            mSft = 0; mThres = MAXPIX; mClipEn = 0;
        end else begin
            expVld = vldNext;
            if (vldNext) expCnt = pendCnt;
            vldNext = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            n++;
        end
        checkOutput("drain_timeout", expq.size(), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit v;
        bit sof;
        bit eof;
        rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_data = '0;
        cfg_y_gain_sft = '0; cfg_thres_bayer = '0; cfg_clip_en = 1'b0; m_ready = 1'b0;
        rstReq = 1'b0; cfgSftReq = 0; cfgThresReq = MAXPIX; cfgClipEnReq = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_sof", m_sof, 0);
        checkOutput("rst_m_eof", m_eof, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_clip_cnt", clip_cnt, 0);
        checkOutput("rst_clip_cnt_vld", clip_cnt_vld, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        rstReq = 1'b1;

        // Pass-through beat and exact two-cycle latency.
        cfgSftReq = 0; cfgClipEnReq = 0; cfgThresReq = 123; vldCount = 0;
        applyStimulus(1, 1, 0, 1000, 16383, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("lat_cyc1_valid", lastValid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("lat_cyc2_valid", lastValid, 1);
        checkOutput("lat_cyc2_data", lastData, {14'd16383, 14'd1000});

        // Low and high clamp on the eof beat of the same frame.
        applyStimulus(1, 0, 1, -5, 20000, 1);
        drain();
        checkOutput("neg_hi_data", lastFireData, {14'd16383, 14'd0});
        checkOutput("neg_hi_clip_cnt", lastClipCnt, 2);
        checkOutput("neg_hi_strobes", vldCount, 1);

        // Threshold clip with a shift of 4.
        cfgSftReq = 4; cfgClipEnReq = 1; cfgThresReq = 8000; vldCount = 0;
        applyStimulus(1, 1, 1, 262144, 64000, 1);
        drain();
        checkOutput("thres_data", lastFireData, {14'd4000, 14'd8000});
        checkOutput("thres_clip_cnt", lastClipCnt, 1);
        checkOutput("thres_strobes", vldCount, 1);

        // Shift change mid-frame only takes effect at the next sof.
        cfgSftReq = 2; cfgClipEnReq = 0; cfgThresReq = MAXPIX;
        applyStimulus(1, 1, 0, 400, 800, 1);
        cfgSftReq = 0;
        applyStimulus(1, 0, 0, 400, -8, 1);
        applyStimulus(1, 0, 1, 1000, 4, 1);
        drain();
        checkOutput("midcfg_old_sft", lastFireData, {14'd1, 14'd250});
        applyStimulus(1, 1, 1, 400, 800, 1);
        drain();
        checkOutput("midcfg_new_sft", lastFireData, {14'd800, 14'd400});

        // Continuous stream with a three-cycle downstream stall.
        cfgSftReq = 0; cfgClipEnReq = 0; cfgThresReq = MAXPIX;
        for (int i = 0; i < 6; i++) applyStimulus(1, i == 0, 0, i * 100 + 7, i * 300 + 1, 1);
        applyStimulus(1, 0, 0, 777, 888, 0);
        applyStimulus(1, 0, 0, 777, 888, 0);
        checkOutput("stall_s_ready", lastSReady, 0);
        checkOutput("stall_m_valid", lastValid, 1);
        applyStimulus(1, 0, 0, 777, 888, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, i == 5, i * 50 + 3, 20000 - i, 1);
        drain();

        // Randomized frames, config and backpressure.
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 4) != 0);
            sof = v && ($urandom_range(0, 9) == 0);
            eof = v && ($urandom_range(0, 7) == 0);
            cfgSftReq    = int'($urandom_range(0, 15));
            cfgThresReq  = int'($urandom_range(0, MAXPIX));
            cfgClipEnReq = bit'($urandom_range(0, 1));
            applyStimulus(v, sof, eof, rndSample(), rndSample(), $urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with two beats in flight.
        cfgSftReq = 0; cfgClipEnReq = 0; cfgThresReq = MAXPIX;
        applyStimulus(1, 1, 1, -1, -1, 1);
        drain();
        checkOutput("pre_rst_clip_cnt", lastClipCnt, 2);
        applyStimulus(1, 1, 0, 10, 20, 1);
        applyStimulus(1, 0, 0, 30, 40, 1);
        rstReq = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1);
        rstReq = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("post_rst_m_valid", lastValid, 0);
        checkOutput("post_rst_clip_cnt", lastClipCnt, 0);
        checkOutput("post_rst_s_ready", lastSReady, 1);

        // Before any sof the default config applies, whatever the pins say.
        cfgSftReq = 3; cfgClipEnReq = 1; cfgThresReq = 100; vldCount = 0;
        applyStimulus(1, 0, 1, 7, 20000, 1);
        drain();
        checkOutput("default_cfg_data", lastFireData, {14'd16383, 14'd7});
        checkOutput("default_cfg_clip_cnt", lastClipCnt, 1);
        cfgSftReq = 0; cfgClipEnReq = 0; cfgThresReq = MAXPIX;
        applyStimulus(1, 1, 1, 50, -3, 1);
        drain();
        checkOutput("after_rst_data", lastFireData, {14'd0, 14'd50});
        checkOutput("after_rst_clip_cnt", lastClipCnt, 1);
        checkOutput("after_rst_strobes", vldCount, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
